// File: rtl/irq_pending_ctrl8_if.sv
// irq_pending_ctrl8_if: presentation handshake between the interrupt pending
// controller (master) and the consumer of interrupt ids (slave).
//   id       : index of the presented request (master -> slave)
//   id_valid : id is valid, held stable until accepted (master -> slave)
//   id_ready : consumer accepts id (slave -> master)
interface irq_pending_ctrl8_if;
   logic [2:0] id;
   logic       id_valid;
   logic       id_ready;

   modport master (
      output id,
      output id_valid,
      input  id_ready
   );

   modport slave (
      input  id,
      input  id_valid,
      output id_ready
   );
endinterface

// File: rtl/irq_pending_ctrl8.sv
// irq_pending_ctrl8: 8-line rising-edge interrupt collector with a mask and a
// fixed-priority (bit 7 highest) id presenter using a valid/ready handshake.
// Latency: edge on req_in -> pending after 1 clk -> id_valid after 2 clks.
// Backpressure: a presented id is held until id_ready; new edges keep
// accumulating in pending meanwhile. At most one acceptance per 2 cycles.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   req_in[7:0]    : request lines, edge-detected
//   mask_we        : mask write strobe, mask_wdata[7:0] new mask (1 = enabled)
//   mask[7:0]      : current mask register
//   pending[7:0]   : current pending register
//   bus (master)   : id / id_valid / id_ready presentation handshake
//   ovf, ovf_clr   : sticky overflow flag and its clear (only with IRQ_OVF_EN)
//
// Optional feature macro: IRQ_OVF_EN (adds ovf/ovf_clr and overflow logic).
module irq_pending_ctrl8 #(
   parameter logic [7:0] MASK_RST     = 8'hFF,
   parameter logic [7:0] REQ_IDLE_RST = 8'hFF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [7:0]                 req_in,
   input  logic                       mask_we,
   input  logic [7:0]                 mask_wdata,
   output logic [7:0]                 mask,
   output logic [7:0]                 pending,
   irq_pending_ctrl8_if.master        bus
`ifdef IRQ_OVF_EN
   ,
   output logic                       ovf,
   input  logic                       ovf_clr
`endif
);

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [2:0] id_q;
   logic [2:0] id_nxt;
   logic [2:0] top_idx;
   logic [7:0] req_q;
   logic [7:0] rise;
   logic [7:0] eligible;
   logic [7:0] clr;
   logic       id_valid_c;
   logic       accept;

   // ------------------------------------------------------------------
   // Edge detection and eligibility
   // ------------------------------------------------------------------
   // req_q resets to REQ_IDLE_RST (all ones by default) so that lines
   // already high when reset is released do not look like fresh edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q <= REQ_IDLE_RST;
      end else begin
         req_q <= req_in;
      end
   end

   assign rise     = req_in & ~req_q;
   // Masked bits stay in pending; they only become eligible once unmasked.
   assign eligible = pending & mask;

   // Highest set index wins: later iterations overwrite earlier ones.
   always_comb begin
      top_idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (eligible[i]) begin
            top_idx = 3'(i);
         end
      end
   end

   // ------------------------------------------------------------------
   // Presenter FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         id_q  <= 3'd0;
      end else begin
         state <= state_nxt;
         id_q  <= id_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Presenter FSM: next-state logic
   // ------------------------------------------------------------------
   // id is captured only on the IDLE->PRESENT transition, so mask changes
   // or higher-priority edges can never alter an id already presented.
   // The return to IDLE after each acceptance enforces the gap cycle.
   always_comb begin
      state_nxt = state;
      id_nxt    = id_q;
      case (state)
         ST_IDLE: begin
            if (|eligible) begin
               state_nxt = ST_PRESENT;
               id_nxt    = top_idx;
            end
         end
         ST_PRESENT: begin
            if (bus.id_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Presenter FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      id_valid_c = (state == ST_PRESENT);
      accept     = id_valid_c & bus.id_ready;
      clr        = accept ? (8'd1 << id_q) : 8'd0;
   end

   assign bus.id       = id_q;
   assign bus.id_valid = id_valid_c;

   // ------------------------------------------------------------------
   // Pending and mask registers
   // ------------------------------------------------------------------
   // OR-ing rise after the clear makes a same-cycle edge win over the
   // acceptance of that bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 8'd0;
      end else begin
         pending <= (pending & ~clr) | rise;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask <= MASK_RST;
      end else if (mask_we) begin
         mask <= mask_wdata;
      end
   end

`ifdef IRQ_OVF_EN
   // ------------------------------------------------------------------
   // Overflow: an edge landed on a bit that stays pending this cycle,
   // i.e. one interrupt occurrence was merged into another. Set wins
   // over ovf_clr.
   // ------------------------------------------------------------------
   logic ovf_set;

   assign ovf_set = |(rise & pending & ~clr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (ovf_set) begin
         ovf <= 1'b1;
      end else if (ovf_clr) begin
         ovf <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_irq_pending_ctrl8.sv
// tb_irq_pending_ctrl8: directed checks of irq_pending_ctrl8 with
// hand-computed expected values.
module tb_irq_pending_ctrl8;

   logic       clk;
   logic       rst_n;
   logic [7:0] req_in;
   logic       mask_we;
   logic [7:0] mask_wdata;
   logic [7:0] mask;
   logic [7:0] pending;
`ifdef IRQ_OVF_EN
   logic       ovf;
   logic       ovf_clr;
`endif

   int errors = 0;
   int checks = 0;

   irq_pending_ctrl8_if bus ();

   irq_pending_ctrl8 #(
      .MASK_RST     (8'hFF),
      .REQ_IDLE_RST (8'hFF)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_in     (req_in),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .mask       (mask),
      .pending    (pending),
      .bus        (bus)
`ifdef IRQ_OVF_EN
      ,
      .ovf        (ovf),
      .ovf_clr    (ovf_clr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One cycle: wait for the rising edge, then settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      req_in       = 8'h00;
      mask_we      = 1'b0;
      mask_wdata   = 8'h00;
      bus.id_ready = 1'b0;
`ifdef IRQ_OVF_EN
      ovf_clr      = 1'b0;
`endif

      // ---------------- reset state ----------------
      #12;
      chk("rst_pending",  pending,             8'h00);
      chk("rst_mask",     mask,                8'hFF);
      chk("rst_id_valid", {7'd0, bus.id_valid}, 8'h00);
      chk("rst_id",       {5'd0, bus.id},       8'h00);
`ifdef IRQ_OVF_EN
      chk("rst_ovf",      {7'd0, ovf},          8'h00);
`endif
      rst_n = 1'b1;
      tick();                         // req_q loads 00

      // ---------------- basic two-bit pulse ----------------
      req_in = 8'h24;
      tick();
      chk("b_pend1",  pending, 8'h24);
      chk("b_vld1",   {7'd0, bus.id_valid}, 8'h00);
      req_in = 8'h00;
      tick();
      chk("b_vld2",   {7'd0, bus.id_valid}, 8'h01);
      chk("b_id5",    {5'd0, bus.id}, 8'd5);
      bus.id_ready = 1'b1;
      tick();
      chk("b_pend2",  pending, 8'h04);
      chk("b_vld3",   {7'd0, bus.id_valid}, 8'h00);
      tick();                         // id_ready high while idle: no effect
      chk("b_id2",    {5'd0, bus.id}, 8'd2);
      chk("b_vld4",   {7'd0, bus.id_valid}, 8'h01);
      chk("b_pend3",  pending, 8'h04);
      tick();
      bus.id_ready = 1'b0;
      chk("b_pend4",  pending, 8'h00);

      // ---------------- reset while presenting ----------------
      req_in = 8'h08;
      tick();
      req_in = 8'h00;
      tick();
      chk("r_vld_pre", {7'd0, bus.id_valid}, 8'h01);
      rst_n  = 1'b0;
      req_in = 8'hFF;
      #1;
      chk("r_vld_async",  {7'd0, bus.id_valid}, 8'h00);
      chk("r_id_async",   {5'd0, bus.id}, 8'd0);
      chk("r_pend_async", pending, 8'h00);
      #2;
      rst_n = 1'b1;
      // lines held high through reset release create no pending bits
      for (int i = 0; i < 4; i++) tick();
      chk("h_pend", pending, 8'h00);
      chk("h_vld",  {7'd0, bus.id_valid}, 8'h00);

      // ---------------- masking ----------------
      req_in     = 8'h00;
      mask_we    = 1'b1;
      mask_wdata = 8'h7F;
      tick();
      mask_we = 1'b0;
      chk("m_mask", mask, 8'h7F);
      req_in = 8'h81;
      tick();
      req_in = 8'h00;
      chk("m_pend1", pending, 8'h81);
      tick();
      chk("m_id0",  {5'd0, bus.id}, 8'd0);
      chk("m_vld1", {7'd0, bus.id_valid}, 8'h01);
      bus.id_ready = 1'b1;
      tick();
      bus.id_ready = 1'b0;
      chk("m_pend2", pending, 8'h80);
      tick();
      chk("m_vld2", {7'd0, bus.id_valid}, 8'h00);
      mask_we    = 1'b1;
      mask_wdata = 8'hFF;
      tick();
      mask_we = 1'b0;
      chk("m_vld3", {7'd0, bus.id_valid}, 8'h00);
      tick();
      chk("m_id7",  {5'd0, bus.id}, 8'd7);
      chk("m_vld4", {7'd0, bus.id_valid}, 8'h01);
      bus.id_ready = 1'b1;
      tick();
      bus.id_ready = 1'b0;
      chk("m_pend3", pending, 8'h00);

      // ---------------- hold under backpressure ----------------
      req_in = 8'h08;
      tick();
      req_in = 8'h00;
      tick();
      for (int i = 0; i < 5; i++) begin
         req_in = (i == 1) ? 8'h40 : 8'h00;
         tick();
         chk("s_id3",  {5'd0, bus.id}, 8'd3);
         chk("s_vld",  {7'd0, bus.id_valid}, 8'h01);
      end
      req_in = 8'h00;
      chk("s_pend1", pending, 8'h48);
      bus.id_ready = 1'b1;
      tick();
      bus.id_ready = 1'b0;
      chk("s_pend2", pending, 8'h40);
      tick();
      chk("s_id6", {5'd0, bus.id}, 8'd6);
      bus.id_ready = 1'b1;
      tick();
      bus.id_ready = 1'b0;
      chk("s_pend3", pending, 8'h00);

      // ---------------- set wins over clear ----------------
      req_in = 8'h08;
      tick();
      req_in = 8'h00;
      tick();
      chk("w_id3a", {5'd0, bus.id}, 8'd3);
      req_in       = 8'h08;
      bus.id_ready = 1'b1;
      tick();
      req_in       = 8'h00;
      bus.id_ready = 1'b0;
      chk("w_pend", pending, 8'h08);
      chk("w_vld0", {7'd0, bus.id_valid}, 8'h00);
`ifdef IRQ_OVF_EN
      chk("w_ovf",  {7'd0, ovf}, 8'h00);
`endif
      tick();
      chk("w_id3b", {5'd0, bus.id}, 8'd3);
      chk("w_vld1", {7'd0, bus.id_valid}, 8'h01);
      bus.id_ready = 1'b1;
      tick();
      bus.id_ready = 1'b0;
      chk("w_pend2", pending, 8'h00);

      // ---------------- double pulse on an unaccepted bit ----------------
      req_in = 8'h02;
      tick();
      req_in = 8'h00;
      tick();
      chk("o_id1", {5'd0, bus.id}, 8'd1);
      req_in = 8'h02;
      tick();
      req_in = 8'h00;
      chk("o_pend", pending, 8'h02);
      chk("o_id1b", {5'd0, bus.id}, 8'd1);
`ifdef IRQ_OVF_EN
      chk("o_ovf_set", {7'd0, ovf}, 8'h01);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("o_ovf_clr", {7'd0, ovf}, 8'h00);
      req_in  = 8'h02;
      ovf_clr = 1'b1;
      tick();
      req_in  = 8'h00;
      ovf_clr = 1'b0;
      chk("o_ovf_win", {7'd0, ovf}, 8'h01);
`endif
      bus.id_ready = 1'b1;
      tick();
      bus.id_ready = 1'b0;
      chk("o_pend_end", pending, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
